// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues fixed-latency memory requests,
// queues returned instructions with their PCs, and resolves branch/jump/jr redirects.
module fetch_unit #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned            DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  redirect,
    input  logic [1:0]            redirect_kind,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic [25:0]           redirect_field,
    input  logic [ADDR_WIDTH-1:0] redirect_reg,
    output logic                  align_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  align_err_q, align_err_d;

    logic [31:0]           instr_mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem_q    [DEPTH];

    logic                  push_c;
    logic                  pop_c;
    logic [CNT_W:0]        used_c;
    logic [ADDR_WIDTH-1:0] p4_c;
    logic [ADDR_WIDTH-1:0] target_c;
    logic [31:0]           boff_c;
    logic [31:0]           p4_ext_c;
    logic [31:0]           jt_ext_c;

    // Credit check counts queued plus in-flight entries; a same-cycle pop is not credited.
    assign used_c   = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
    assign imem_req = reset & ~redirect & (used_c < (CNT_W+1)'(DEPTH));
    assign push_c   = inflight_q & ~redirect;
    assign pop_c    = (count_q != '0) & instr_ready & ~redirect;

    assign imem_addr   = fetch_pc_q;
    assign instr       = instr_mem_q[rd_ptr_q];
    assign instr_pc    = pc_mem_q[rd_ptr_q];
    assign instr_valid = (count_q != '0);
    assign align_err   = align_err_q;

    // Redirect target: branch, jump (region of pc+4), or word-aligned register.
    always_comb begin
        p4_c     = redirect_pc + ADDR_WIDTH'(4);
        boff_c   = {{14{redirect_field[15]}}, redirect_field[15:0], 2'b00};
        p4_ext_c = '0;
        p4_ext_c[ADDR_WIDTH-1:0] = p4_c;
        jt_ext_c = (p4_ext_c & 32'hF000_0000) | {4'b0000, redirect_field, 2'b00};
        unique case (redirect_kind)
            2'b00:   target_c = p4_c + boff_c[ADDR_WIDTH-1:0];
            2'b01:   target_c = jt_ext_c[ADDR_WIDTH-1:0];
            default: target_c = {redirect_reg[ADDR_WIDTH-1:2], 2'b00};
        endcase
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        align_err_d   = 1'b0;
        if (redirect) begin
            fetch_pc_d  = target_c;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            align_err_d = redirect_kind[1] & (redirect_reg[1:0] != 2'b00);
        end else begin
            if (imem_req) begin
                fetch_pc_d    = fetch_pc_q + ADDR_WIDTH'(4);
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
            end
            if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            align_err_q   <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            align_err_q   <= align_err_d;
            if (push_c) begin
                instr_mem_q[wr_ptr_q] <= imem_rdata;
                pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases push expected PCs, a monitor checks every pop.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [1:0]  redirect_kind;
    logic [31:0] redirect_pc;
    logic [25:0] redirect_field;
    logic [31:0] redirect_reg;
    logic        align_err;

    logic        req16;
    logic [15:0] addr16;
    logic [31:0] rdata16;
    logic [31:0] instr16;
    logic [15:0] pc16;
    logic        valid16;
    logic        aerr16;

    int unsigned n_asserts;
    int unsigned n_fail;
    logic [31:0] sb [$];

    fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect),
        .redirect_kind(redirect_kind), .redirect_pc(redirect_pc),
        .redirect_field(redirect_field), .redirect_reg(redirect_reg), .align_err(align_err)
    );

    fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(16'hFFF8), .DEPTH(4)) dut16 (
        .clk(clk), .reset(reset), .imem_req(req16), .imem_addr(addr16),
        .imem_rdata(rdata16), .instr(instr16), .instr_pc(pc16),
        .instr_valid(valid16), .instr_ready(1'b1), .redirect(1'b0),
        .redirect_kind(2'b00), .redirect_pc(16'h0), .redirect_field(26'h0),
        .redirect_reg(16'h0), .align_err(aerr16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mdl(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
    endfunction

    // One-cycle memory; non-requested cycles return junk so stray pushes show up.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mdl(imem_addr) : 32'hDEAD_BEEF;
        rdata16    <= req16 ? mdl({16'h0, addr16}) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted head entry must match the scoreboard front.
    always @(negedge clk) begin
        if (reset && instr_valid && instr_ready && !redirect) begin
            if (sb.size() == 0) begin
                n_asserts++;
                n_fail++;
                $display("FAIL unexpected_pop: got pc %h with no expected entry at %0t", instr_pc, $time);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                chk("pop_pc", instr_pc, e);
                chk("pop_instr", instr, mdl(e));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) sb.push_back(base + 32'(4 * i));
    endtask

    // Wait until all expected pops happened, then stop consumption (or assert reset).
    task automatic drain(input bit do_reset);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 60) begin
            step();
            k++;
        end
        if (sb.size() != 0) begin
            n_asserts++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d entries left expected 0", sb.size());
            sb.delete();
        end
        if (do_reset) reset = 1'b0;
        else          instr_ready = 1'b0;
    endtask

    initial begin
        n_asserts = 0;
        n_fail = 0;
        reset = 1'b0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_kind = 2'b00;
        redirect_pc = '0;
        redirect_field = '0;
        redirect_reg = '0;
        step();
        step();
        #1;
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_aerr", 32'(align_err), 0);
        chk("rst_addr16", 32'(addr16), 32'hFFF8);

        // Backpressure from reset: exactly four requests; 16-bit instance wraps.
        step();
        reset = 1'b1;
        #1;
        chk("c0_req", 32'(imem_req), 1);
        chk("c0_addr", imem_addr, 0);
        chk("c0_valid", 32'(instr_valid), 0);
        chk("w16_addr0", 32'(addr16), 32'hFFF8);
        for (int i = 1; i < 8; i++) begin
            step();
            #1;
            chk("bp_req", 32'(imem_req), (i < 4) ? 1 : 0);
            if (i < 4) chk("bp_addr", imem_addr, 32'(4 * i));
            chk("bp_valid", 32'(instr_valid), (i >= 2) ? 1 : 0);
            if (i == 2) chk("bp_head_pc", instr_pc, 0);
            if (i == 1) chk("w16_addr1", 32'(addr16), 32'hFFFC);
            if (i == 2) chk("w16_addr2", 32'(addr16), 32'h0000);
            if (i == 2) chk("w16_pc2", 32'(pc16), 32'hFFF8);
            if (i == 3) chk("w16_pc3", 32'(pc16), 32'hFFFC);
            if (i == 4) chk("w16_pc4", 32'(pc16), 32'h0000);
        end
        instr_ready = 1'b1;
        push_seq(32'h0, 12);
        #1;
        chk("no_pop_credit", 32'(imem_req), 0);
        step();
        #1;
        chk("resume_req", 32'(imem_req), 1);
        chk("resume_addr", imem_addr, 32'h10);
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            chk("thru_req", 32'(imem_req), 1);
            chk("thru_valid", 32'(instr_valid), 1);
        end
        drain(1'b0);

        // Branch with live queue and in-flight request.
        step();
        redirect = 1'b1;
        redirect_kind = 2'b00;
        redirect_pc = 32'h40;
        redirect_field = 26'h000FFFE;
        #1;
        chk("br_req_R", 32'(imem_req), 0);
        chk("br_live", 32'(instr_valid), 1);
        step();
        redirect = 1'b0;
        #1;
        chk("br_addr", imem_addr, 32'h3C);
        chk("br_req", 32'(imem_req), 1);
        chk("br_flushed", 32'(instr_valid), 0);
        instr_ready = 1'b1;
        push_seq(32'h3C, 4);
        step();
        #1;
        chk("br_valid_R2", 32'(instr_valid), 0);
        step();
        #1;
        chk("br_valid_R3", 32'(instr_valid), 1);
        chk("br_pc_R3", instr_pc, 32'h3C);
        drain(1'b0);

        // Jump into the 0xF region.
        step();
        redirect = 1'b1;
        redirect_kind = 2'b01;
        redirect_pc = 32'hF000_0010;
        redirect_field = 26'h0000100;
        #1;
        chk("j_req_R", 32'(imem_req), 0);
        step();
        redirect = 1'b0;
        #1;
        chk("j_addr", imem_addr, 32'hF000_0400);
        instr_ready = 1'b1;
        push_seq(32'hF000_0400, 3);
        drain(1'b0);

        // Misaligned register target.
        step();
        redirect = 1'b1;
        redirect_kind = 2'b10;
        redirect_reg = 32'h1003;
        #1;
        step();
        redirect = 1'b0;
        #1;
        chk("jr_addr", imem_addr, 32'h1000);
        chk("jr_aerr", 32'(align_err), 1);
        instr_ready = 1'b1;
        push_seq(32'h1000, 2);
        step();
        #1;
        chk("jr_aerr_pulse", 32'(align_err), 0);
        drain(1'b0);

        // Redirect (kind 11, aligned) with a same-cycle pop that must be ignored.
        step();
        step();
        #1;
        chk("rp_live", 32'(instr_valid), 1);
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_kind = 2'b11;
        redirect_reg = 32'h2000;
        #1;
        chk("rp_req_R", 32'(imem_req), 0);
        step();
        redirect = 1'b0;
        #1;
        chk("rp_valid", 32'(instr_valid), 0);
        chk("rp_addr", imem_addr, 32'h2000);
        chk("rp_aerr", 32'(align_err), 0);
        push_seq(32'h2000, 3);
        drain(1'b1);

        // Reset asserted mid-stream.
        #1;
        chk("mr_req", 32'(imem_req), 0);
        chk("mr_valid", 32'(instr_valid), 0);
        chk("mr_instr", instr, 0);
        chk("mr_pc", instr_pc, 0);
        chk("mr_addr", imem_addr, 0);
        step();
        #1;
        chk("mr_valid2", 32'(instr_valid), 0);
        step();
        reset = 1'b1;
        #1;
        chk("rr_addr", imem_addr, 0);
        chk("rr_req", 32'(imem_req), 1);
        push_seq(32'h0, 3);
        step();
        #1;
        chk("rr_valid1", 32'(instr_valid), 0);
        drain(1'b0);

        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
